// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: serial byte handshake plus instruction-memory write port of the boot loader
interface imem_boot_loader_if #(parameter int ADDR_WIDTH = 8);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed, XOR-checked byte stream into imem words, then releases the core
module imem_boot_loader #(parameter int ADDR_WIDTH = 8) (
  input logic clk,
  input logic reset,
  input logic reload,
  imem_boot_loader_if.slave bus,
  output logic core_run,
  output logic load_err,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, CSUM, DONE, ERROR} state_t;
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;
  state_t state;
  logic [7:0] len_lo;
  logic [7:0] csum;
  logic [15:0] n;
  logic [1:0] lane;
  logic [23:0] word;
  logic take;
  logic [15:0] len;
  assign take = bus.rx_valid & bus.rx_ready;
  assign len = {bus.rx_data, len_lo};
  // rx_ready is a register cleared by reset, so it rises on the first edge after release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= HDR0;
      len_lo <= '0;
      csum <= '0;
      n <= '0;
      lane <= '0;
      word <= '0;
      bus.rx_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      core_run <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      bus.rx_ready <= 1'b1;
      case (state)
        HDR0: if (take) begin
          len_lo <= bus.rx_data;
          state <= HDR1;
        end
        HDR1: if (take) begin
          n <= len;
          if ({1'b0, len} > CAP) begin
            state <= ERROR;
            load_err <= 1'b1;
            bus.rx_ready <= 1'b0;
          end else state <= (len == 16'd0) ? CSUM : PAYLOAD;
        end
        PAYLOAD: if (take) begin
          csum <= csum ^ bus.rx_data;
          lane <= lane + 2'd1;
          word <= {bus.rx_data, word[23:8]};
          if (lane == 2'd3) begin
            bus.imem_we <= 1'b1;
            bus.imem_addr <= words_loaded[ADDR_WIDTH-1:0];
            bus.imem_wdata <= {bus.rx_data, word};
            words_loaded <= words_loaded + 16'd1;
            if (words_loaded + 16'd1 == n) state <= CSUM;
          end
        end
        CSUM: if (take) begin
          bus.rx_ready <= 1'b0;
          if (bus.rx_data == csum) begin
            state <= DONE;
            core_run <= 1'b1;
          end else begin
            state <= ERROR;
            load_err <= 1'b1;
          end
        end
        default: if (reload) begin
          state <= HDR0;
          core_run <= 1'b0;
          load_err <= 1'b0;
          words_loaded <= '0;
          csum <= '0;
          lane <= '0;
          word <= '0;
        end else bus.rx_ready <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with hand-computed writes, checksum outcomes and handshake states
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reload = 1'b0;
  logic core_run, load_err;
  logic [15:0] words_loaded;
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int base;
  logic [7:0] wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  logic [7:0] cs;
  imem_boot_loader_if #(.ADDR_WIDTH(8)) bus ();
  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .reload(reload), .bus(bus.slave),
    .core_run(core_run), .load_err(load_err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.imem_we && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = bus.imem_addr;
      wr_data[wr_cnt] = bus.imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 20 && !bus.rx_ready; t++) begin
      @(posedge clk); #1;
    end
    chk("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask
  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask
  task automatic frame2(input logic [7:0] c, input int gap);
    logic [7:0] f [0:10];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    f[10] = c;
    for (int i = 0; i < 11; i++) send(f[i], gap);
  endtask
  task automatic chk_two(input string tag);
    chk({tag, "_nwr"}, 32'(wr_cnt - base), 32'd2);
    chk({tag, "_a0"}, 32'(wr_addr[base]), 32'd0);
    chk({tag, "_d0"}, wr_data[base], 32'h00000013);
    chk({tag, "_a1"}, 32'(wr_addr[base+1]), 32'd1);
    chk({tag, "_d1"}, wr_data[base+1], 32'h00100093);
    chk({tag, "_wl"}, 32'(words_loaded), 32'd2);
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_rx_ready", 32'(bus.rx_ready), 32'd1);
    // two-word program, back to back, with per-write timing checks
    base = wr_cnt;
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("w0_we", 32'(bus.imem_we), 32'd1);
    chk("w0_addr", 32'(bus.imem_addr), 32'd0);
    chk("w0_data", bus.imem_wdata, 32'h00000013);
    chk("w0_words", 32'(words_loaded), 32'd1);
    send(8'h93, 0);
    chk("w0_we_drop", 32'(bus.imem_we), 32'd0);
    send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    chk("w1_we", 32'(bus.imem_we), 32'd1);
    chk("w1_addr", 32'(bus.imem_addr), 32'd1);
    chk("run_before_csum", 32'(core_run), 32'd0);
    send(8'h90, 0);
    chk("t1_core_run", 32'(core_run), 32'd1);
    chk("t1_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("t1_load_err", 32'(load_err), 32'd0);
    chk_two("t1");
    // reload from DONE
    pulse_reload();
    chk("rl_core_run", 32'(core_run), 32'd0);
    chk("rl_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rl_words", 32'(words_loaded), 32'd0);
    base = wr_cnt;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h37, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h32, 0);
    chk("rl_nwr", 32'(wr_cnt - base), 32'd1);
    chk("rl_a0", 32'(wr_addr[base]), 32'd0);
    chk("rl_d0", wr_data[base], 32'h00000537);
    chk("rl_run", 32'(core_run), 32'd1);
    // bad checksum
    pulse_reload();
    base = wr_cnt;
    frame2(8'h91, 0);
    chk_two("bad");
    chk("bad_load_err", 32'(load_err), 32'd1);
    chk("bad_core_run", 32'(core_run), 32'd0);
    chk("bad_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("bad_err_sticky", 32'(load_err), 32'd1);
    pulse_reload();
    chk("bad_rl_err", 32'(load_err), 32'd0);
    chk("bad_rl_rx_ready", 32'(bus.rx_ready), 32'd1);
    // oversize header N = 257
    base = wr_cnt;
    send(8'h01, 0); send(8'h01, 0);
    chk("big_load_err", 32'(load_err), 32'd1);
    chk("big_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("big_nwr", 32'(wr_cnt - base), 32'd0);
    pulse_reload();
    // full capacity N = 256, word i = {i, 8'h5A, ~i, i}
    base = wr_cnt;
    cs = 8'h00;
    send(8'h00, 0); send(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0); send(~8'(i), 0); send(8'h5A, 0); send(8'(i), 0);
      cs = cs ^ 8'(i) ^ ~8'(i) ^ 8'h5A ^ 8'(i);
    end
    send(cs, 0);
    chk("cap_nwr", 32'(wr_cnt - base), 32'd256);
    chk("cap_last_addr", 32'(wr_addr[base+255]), 32'h000000FF);
    chk("cap_last_data", wr_data[base+255], 32'hFF5A00FF);
    chk("cap_a17", 32'(wr_addr[base+17]), 32'h00000011);
    chk("cap_d17", wr_data[base+17], 32'h115AEE11);
    chk("cap_words", 32'(words_loaded), 32'd256);
    chk("cap_run", 32'(core_run), 32'd1);
    // empty frame
    pulse_reload();
    base = wr_cnt;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("empty_run", 32'(core_run), 32'd1);
    chk("empty_nwr", 32'(wr_cnt - base), 32'd0);
    chk("empty_words", 32'(words_loaded), 32'd0);
    // reload is ignored in HDR0
    pulse_reload();
    pulse_reload();
    chk("rl_ign_rx_ready", 32'(bus.rx_ready), 32'd1);
    // flow control gaps
    base = wr_cnt;
    frame2(8'h90, 3);
    chk_two("gap");
    chk("gap_run", 32'(core_run), 32'd1);
    chk("gap_rx_ready", 32'(bus.rx_ready), 32'd0);
    // asynchronous reset after 6 payload bytes
    pulse_reload();
    send(8'h02, 0); send(8'h00, 0);
    for (int i = 0; i < 6; i++) send(8'hC3, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("mid_we", 32'(bus.imem_we), 32'd0);
    chk("mid_addr", 32'(bus.imem_addr), 32'd0);
    chk("mid_wdata", bus.imem_wdata, 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    chk("mid_run", 32'(core_run), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    base = wr_cnt;
    frame2(8'h90, 0);
    chk_two("mid");
    chk("mid_core_run", 32'(core_run), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader that sits directly upstream of the RISC-V core and its instruction memory. It accepts a byte stream from a serial receiver, assembles little-endian 32-bit instruction words, and writes them into the instruction-memory write port. It checks an XOR checksum, then releases the core from hold by asserting `core_run`. While loading, the core is held: `core_run` low keeps the processor, with its PC at 0, in reset.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  `rx_data` is valid this cycle.
- `rx_ready`  output  1  loader can accept a byte this cycle.
- `reload`  input  1  single-cycle request to restart loading from DONE or ERROR.
- `imem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  output  ADDR_WIDTH  word address of the current write.
- `imem_wdata`  output  32  assembled instruction word.
- `core_run`  output  1  high means the core is released; low holds the core in reset.
- `load_err`  output  1  sticky error flag.
- `words_loaded`  output  16  number of words written in the current load.

## Operation
- A byte is accepted on any clock edge where `rx_valid && rx_ready`. No other condition consumes a byte.
- Frame format: `LEN_LO`, `LEN_HI` (16-bit word count N), then 4·N payload bytes with the least significant byte first per word, then one `CSUM` byte. `CSUM` is the XOR of all payload bytes only; header bytes are excluded.
- States and transitions:
  - **HDR0**: store `LEN_LO`, go to HDR1.
  - **HDR1**: store `LEN_HI` and form N.
    - If N > 2^ADDR_WIDTH, go to ERROR.
    - If N == 0, go to CSUM.
    - Otherwise go to PAYLOAD.
  - **PAYLOAD**:
    - A 2-bit byte counter selects the byte lane, and each payload byte is XORed into a running checksum.
    - On the 4th byte, issue a write at address `words_loaded`, then increment `words_loaded`.
    - After word N−1 is written, go to CSUM.
  - **CSUM**: if the received byte equals the running checksum, go to DONE; otherwise go to ERROR.
  - **DONE**: `core_run` = 1. A `reload` pulse goes to HDR0 and clears `core_run`, `words_loaded`, the checksum and the byte counter.
  - **ERROR**: `load_err` = 1 and `core_run` = 0. A `reload` pulse goes to HDR0 and clears `load_err` plus all the counters.
- `rx_ready` is 1 in HDR0, HDR1, PAYLOAD and CSUM. It is 0 in DONE and ERROR.
- `reload` is ignored in HDR0, HDR1, PAYLOAD and CSUM.
- Arithmetic and width rules:
  - `words_loaded` is 16 bits.
  - `imem_addr` = `words_loaded[ADDR_WIDTH-1:0]`. With N == 2^ADDR_WIDTH, the final address is all-ones and never wraps.
  - The checksum is 8 bits.
- Reset values (asynchronous, when `reset` = 0):
  - state = HDR0.
  - `rx_ready` = 1 once released, 0 during reset.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `core_run` = 0, `load_err` = 0, `words_loaded` = 0.
  - Checksum and byte counter = 0.
- Reset mid-frame discards the partial word and the whole frame. Words already written remain in memory but are not trusted; the next load overwrites them.

## Timing
- All outputs are registered.
- `imem_we`:
  - Asserts for exactly one cycle, in the cycle after the edge that accepts the 4th byte of a word.
  - `imem_addr` and `imem_wdata` are valid in that same cycle.
  - `words_loaded` shows the incremented count in that same cycle.
- `core_run` rises in the cycle after the edge that accepts a matching `CSUM`.
- `load_err` rises in the cycle after the edge that accepts a mismatching `CSUM` or an oversize `LEN_HI`.
- A `reload` accepted on edge k clears `core_run` and `load_err` from cycle k+1. `rx_ready` = 1 from cycle k+1.
- Back-to-back bytes, with `rx_valid` held high every cycle, are accepted at one byte per cycle with no bubbles. Minimum load time is 3 + 4·N cycles.
- `rx_valid` gaps of any length within a frame are tolerated. The state and partial word are held.

## Test plan
- Two-word program:
  - Stimulus: bytes `02 00`, `13 00 00 00`, `93 00 10 00`, `90`.
  - Response: writes `0x00000013` at address 0 and `0x00100093` at address 1, each as a single-cycle `imem_we`. `core_run` = 1 one cycle after `90` is accepted, `words_loaded` = 2, `rx_ready` = 0.
- Bad checksum:
  - Stimulus: the same frame with `CSUM` = `91`.
  - Response: both writes occur, `load_err` = 1, `core_run` = 0.
  - Follow-up: a `reload` pulse clears `load_err` and returns `rx_ready` = 1.
- Oversize and empty frames, with ADDR_WIDTH = 8:
  - Header `01 01` (N = 257) → ERROR after `LEN_HI`, with no `imem_we` ever.
  - Header `00 01` (N = 256) → 256 writes, the last at address `0xFF`.
  - `00 00 00` → DONE with zero writes.
- Flow control:
  - Stimulus: the two-word frame with `rx_valid` low for 3 cycles between every byte.
  - Response: identical writes and final state as the back-to-back case.
- Reset mid-load:
  - Stimulus: `reset` low asynchronously after 6 payload bytes.
  - Response: every output is immediately at its reset value. A fresh frame then loads correctly starting at address 0.
- Reload from DONE:
  - Stimulus: after a successful load, pulse `reload`, then send `01 00 37 05 00 00 32`.
  - Response: `core_run` drops the cycle after `reload`, `0x00000537` is written at address 0, then `core_run` = 1.
